// File: rtl/relay_pkg.sv
// relay_pkg: shared encodings and default data-path constants for the
// relay gain-ranging blocks (gain_range_detector and its helpers).
package relay_pkg;

  // Default ADC data-path shape: 12-bit offset-binary, midscale 2048.
  localparam int SAMPLE_W_DEF = 12;
  localparam int MID_DEF      = 2048;

  // Detector states; the numeric codes are visible on state_dbg.
  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_DECIDE  = 2'd2
  } state_e;

endpackage

// File: rtl/gain_range_detector_if.sv
// gain_range_detector_if: sample stream in, gain-step requests and debug
// state out. The master side is the sample source / relay counter, the
// slave side is the detector.
interface gain_range_detector_if
  import relay_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
);

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic                hold;
  logic                to_high;
  logic                to_low;
  logic                step_en;
  logic [1:0]          state_dbg;

  modport master (
    output sample_valid, sample, hold,
    input  to_high, to_low, step_en, state_dbg
  );

  modport slave (
    input  sample_valid, sample, hold,
    output to_high, to_low, step_en, state_dbg
  );

endinterface

// File: rtl/gain_range_detector_peak_abs_tracker.sv
// peak_abs_tracker: magnitude of an offset-binary sample about midscale and
// a running peak register. clear wins over set_max, which wins over update.
module peak_abs_tracker
  import relay_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int MID      = MID_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                update,
  input  logic                set_max,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] peak
);

  localparam logic signed [SAMPLE_W:0] MID_S = (SAMPLE_W+1)'(MID);

  logic signed [SAMPLE_W:0] diff_s;
  logic        [SAMPLE_W:0] abs_s;
  logic [SAMPLE_W-1:0]      mag_s;
  logic [SAMPLE_W-1:0]      peak_r;

  // Signed distance from midscale one bit wider than the sample, then
  // absolute value truncated back to sample width (fits when MID is 2^(W-1)).
  always_comb begin
    diff_s = $signed({1'b0, sample}) - MID_S;
    if (diff_s[SAMPLE_W]) begin
      abs_s = $unsigned(-diff_s);
    end else begin
      abs_s = $unsigned(diff_s);
    end
    mag_s = abs_s[SAMPLE_W-1:0];
  end

  // Peak register: cleared between windows, forced full-scale on a clip,
  // otherwise keeps the largest magnitude seen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      peak_r <= {SAMPLE_W{1'b0}};
    end else if (clear) begin
      peak_r <= {SAMPLE_W{1'b0}};
    end else if (set_max) begin
      peak_r <= {SAMPLE_W{1'b1}};
    end else if (update && (mag_s > peak_r)) begin
      peak_r <= mag_s;
    end else begin
      peak_r <= peak_r;
    end
  end

  assign peak = peak_r;

endmodule

// File: rtl/gain_range_detector.sv
// gain_range_detector: measures peak |sample - MID| over a window of accepted
// samples and requests a gain step (to_high: reduce gain, to_low: raise
// gain), then blanks decisions for a settle period after each step.
// Optional build macro GAIN_RANGE_FAST_CLIP_EN: a full-scale sample (all
// zeros or all ones) during acquisition ends the window at once with a
// forced full-scale peak.
module gain_range_detector
  import relay_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int MID       = MID_DEF,
  parameter int WINDOW    = 256,
  parameter int SETTLE    = 64,
  parameter int HI_THRESH = 1800,
  parameter int LO_THRESH = 400
) (
  input logic             clock,
  input logic             reset,
  gain_range_detector_if.slave bus
);

  localparam int CNT_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]    WIN_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]    SET_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [SAMPLE_W-1:0] HI_T     = SAMPLE_W'(HI_THRESH);
  localparam logic [SAMPLE_W-1:0] LO_T     = SAMPLE_W'(LO_THRESH);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic                to_high_r;
  logic                to_low_r;
  logic                step_en_r;
  logic                to_high_nxt_s;
  logic                to_low_nxt_s;
  logic                peak_clr_s;
  logic                peak_upd_s;
  logic                peak_max_s;
  logic                accept_s;
  logic                clip_s;
  logic [SAMPLE_W-1:0] peak_s;

  assign accept_s = bus.sample_valid & ~bus.hold;

`ifdef GAIN_RANGE_FAST_CLIP_EN
  assign clip_s = (bus.sample == {SAMPLE_W{1'b0}}) || (bus.sample == {SAMPLE_W{1'b1}});
`else
  assign clip_s = 1'b0;
`endif

  peak_abs_tracker #(
    .SAMPLE_W (SAMPLE_W),
    .MID      (MID)
  ) u_peak (
    .clock   (clock),
    .reset   (reset),
    .clear   (peak_clr_s),
    .update  (peak_upd_s),
    .set_max (peak_max_s),
    .sample  (bus.sample),
    .peak    (peak_s)
  );

  // Next state, counter and peak control; decides the step request in DECIDE.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    peak_clr_s    = 1'b0;
    peak_upd_s    = 1'b0;
    peak_max_s    = 1'b0;
    to_high_nxt_s = 1'b0;
    to_low_nxt_s  = 1'b0;
    case (state_r)
      ST_SETTLE: begin
        if (accept_s) begin
          if (cnt_r == SET_LAST) begin
            cnt_nxt_s   = {CNT_W{1'b0}};
            peak_clr_s  = 1'b1;
            state_nxt_s = ST_ACQUIRE;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_ACQUIRE: begin
        if (accept_s) begin
          if (clip_s) begin
            peak_max_s  = 1'b1;
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = ST_DECIDE;
          end else begin
            peak_upd_s = 1'b1;
            if (cnt_r == WIN_LAST) begin
              cnt_nxt_s   = {CNT_W{1'b0}};
              state_nxt_s = ST_DECIDE;
            end else begin
              cnt_nxt_s = cnt_r + CNT_ONE;
            end
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_DECIDE: begin
        // Single cycle: any sample offered here is dropped.
        cnt_nxt_s = {CNT_W{1'b0}};
        if (bus.hold) begin
          peak_clr_s  = 1'b1;
          state_nxt_s = ST_ACQUIRE;
        end else if (peak_s >= HI_T) begin
          to_high_nxt_s = 1'b1;
          state_nxt_s   = ST_SETTLE;
        end else if (peak_s < LO_T) begin
          to_low_nxt_s = 1'b1;
          state_nxt_s  = ST_SETTLE;
        end else begin
          // In range: no step, so no settle is needed.
          peak_clr_s  = 1'b1;
          state_nxt_s = ST_ACQUIRE;
        end
      end
      default: begin
        cnt_nxt_s   = {CNT_W{1'b0}};
        peak_clr_s  = 1'b1;
        state_nxt_s = ST_SETTLE;
      end
    endcase
  end

  // State, counter and one-cycle request pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_SETTLE;
      cnt_r     <= {CNT_W{1'b0}};
      to_high_r <= 1'b0;
      to_low_r  <= 1'b0;
      step_en_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      to_high_r <= to_high_nxt_s;
      to_low_r  <= to_low_nxt_s;
      step_en_r <= to_high_nxt_s | to_low_nxt_s;
    end
  end

  assign bus.to_high   = to_high_r;
  assign bus.to_low    = to_low_r;
  assign bus.step_en   = step_en_r;
  assign bus.state_dbg = state_r;

endmodule
